key_debounce: RTL and testbench



---
 rtl/key_debounce.sv | 132 +++++++++++++
 tb/tb_key_debounce.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: per-key synchroniser, debouncer and press-pulse generator.
// Optional hold-to-auto-repeat per key, selected by REPEAT_EN.
module key_debounce #(
  parameter int NUM_KEYS = 2,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int HOLD_CYC = 50000000,
  parameter int REPEAT_CYC = 10000000,
  parameter logic [NUM_KEYS-1:0] REPEAT_EN = NUM_KEYS'(2'b10)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_level
);

  localparam int MAX_AB =
    (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
  localparam int MAX_C =
    (MAX_AB > REPEAT_CYC) ? MAX_AB : REPEAT_CYC;
  // +1 so a power-of-two cycle count still fits in the counter
  localparam int CW = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DB_N = CW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REPEAT,
    RELEASE_DB
  } state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic          s1;
    logic          s2;
    state_t        st;
    logic [CW-1:0] cnt;
    logic          pulse;
    logic          level;

    assign key_pulse[i] = pulse;
    assign key_level[i] = level;

    // two-flop synchroniser, resets to the released level
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1 <= 1'b1;
        s2 <= 1'b1;
      end else begin
        s1 <= key_n[i];
        s2 <= s1;
      end
    end

    // per-key debounce / hold / repeat FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st    <= IDLE;
        cnt   <= '0;
        pulse <= 1'b0;
        level <= 1'b0;
      end else begin
        pulse <= 1'b0;
        unique case (st)
          IDLE: begin
            if (!s2) begin
              st  <= PRESS_DB;
              cnt <= '0;
            end
          end
          PRESS_DB: begin
            if (s2) begin
              st  <= IDLE;
              cnt <= '0;
            end else if (cnt == DB_N) begin
              st    <= HELD;
              cnt   <= '0;
              pulse <= 1'b1;
              level <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            if (s2) begin
              st  <= RELEASE_DB;
              cnt <= '0;
            end else if (cnt != HOLD_LAST) begin
              cnt <= cnt + 1'b1;
            end else if (REPEAT_EN[i]) begin
              st    <= REPEAT;
              cnt   <= '0;
              pulse <= 1'b1;
            end
          end
          REPEAT: begin
            if (s2) begin
              st  <= RELEASE_DB;
              cnt <= '0;
            end else if (cnt == REP_LAST) begin
              cnt   <= '0;
              pulse <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RELEASE_DB: begin
            // a bounce back to pressed restarts the hold timer
            if (!s2) begin
              st  <= HELD;
              cnt <= '0;
            end else if (cnt == DB_N) begin
              st    <= IDLE;
              cnt   <= '0;
              level <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            st  <= IDLE;
            cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed checks of key_debounce with short timings.
// DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=5, repeat on key1 only.
module tb_key_debounce;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key_n = 2'b11;
  logic [1:0] key_pulse;
  logic [1:0] key_level;

  int         n_vec = 0;
  int         n_bad = 0;
  int         tk = 0;
  logic [1:0] prev = 2'b00;
  int         p0q[$];
  int         p1q[$];
  int         exp3[8] = '{8, 28, 33, 38, 43, 48, 53, 58};

  key_debounce #(
    .NUM_KEYS(2),
    .DEBOUNCE_CYC(4),
    .HOLD_CYC(20),
    .REPEAT_CYC(5),
    .REPEAT_EN(2'b10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .key_pulse(key_pulse),
    .key_level(key_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock edge; sample 1 ns later, log pulses by edge index
  task automatic tick();
    @(posedge clk);
    #1;
    tk++;
    chk("no_back_to_back", 32'(key_pulse & prev), 0);
    prev = key_pulse;
    if (key_pulse[0]) p0q.push_back(tk);
    if (key_pulse[1]) p1q.push_back(tk);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic mark();
    tk = 0;
    p0q.delete();
    p1q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pulse", 32'(key_pulse), 0);
    chk("rst_level", 32'(key_level), 0);
    rst_n = 1'b1;
    ticks(3);

    // clean key0 press, 10 cycles low
    mark();
    key_n[0] = 1'b0;
    ticks(7);
    chk("t1_pre_pulse", 32'(key_pulse), 0);
    chk("t1_pre_level", 32'(key_level), 0);
    tick();
    chk("t1_pulse", 32'(key_pulse), 1);
    chk("t1_level", 32'(key_level), 1);
    ticks(2);
    key_n[0] = 1'b1;
    ticks(7);
    chk("t1_level_hold", 32'(key_level), 1);
    tick();
    chk("t1_level_drop", 32'(key_level), 0);
    chk("t1_count", 32'(p0q.size()), 1);
    chk("t1_at", 32'((p0q.size() > 0) ? p0q[0] : -1), 8);
    ticks(4);

    // key0 bounce then stable low
    mark();
    key_n[0] = 1'b0; tick();
    key_n[0] = 1'b1; tick();
    key_n[0] = 1'b0; tick();
    key_n[0] = 1'b1; tick();
    key_n[0] = 1'b0;
    ticks(7);
    chk("t2_no_pulse", 32'(p0q.size()), 0);
    chk("t2_no_level", 32'(key_level), 0);
    tick();
    chk("t2_pulse", 32'(key_pulse), 1);
    key_n[0] = 1'b1;
    ticks(10);
    chk("t2_released", 32'(key_level), 0);
    chk("t2_count", 32'(p0q.size()), 1);

    // key1 held 60 cycles with auto-repeat
    mark();
    key_n[1] = 1'b0;
    ticks(60);
    key_n[1] = 1'b1;
    ticks(6);
    tick();
    chk("t3_level_hold", 32'(key_level), 2);
    tick();
    chk("t3_level_drop", 32'(key_level), 0);
    ticks(10);
    chk("t3_count", 32'(p1q.size()), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_at", 32'((p1q.size() > i) ? p1q[i] : -1),
          32'(exp3[i]));
    end

    // key1 release bounce while held
    mark();
    key_n[1] = 1'b0;
    ticks(8);
    chk("t4_pulse", 32'(key_pulse), 2);
    ticks(4);
    key_n[1] = 1'b1;
    ticks(2);
    key_n[1] = 1'b0;
    ticks(2);
    chk("t4_level_bounce", 32'(key_level), 2);
    ticks(20);
    chk("t4_level", 32'(key_level), 2);
    chk("t4_no_extra", 32'(p1q.size()), 1);
    tick();
    chk("t4_repeat", 32'(key_pulse), 2);
    chk("t4_count", 32'(p1q.size()), 2);

    // async reset while key1 repeating and held
    ticks(2);
    rst_n = 1'b0;
    #1;
    chk("t5_async_pulse", 32'(key_pulse), 0);
    chk("t5_async_level", 32'(key_level), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mark();
    prev = 2'b00;
    ticks(7);
    chk("t5_no_early", 32'(p1q.size()), 0);
    chk("t5_level_low", 32'(key_level), 0);
    tick();
    chk("t5_pulse", 32'(key_pulse), 2);
    key_n[1] = 1'b1;
    ticks(10);
    chk("t5_released", 32'(key_level), 0);

    // both keys on the same edge
    mark();
    key_n = 2'b00;
    ticks(7);
    chk("t6_pre", 32'(key_pulse), 0);
    tick();
    chk("t6_both", 32'(key_pulse), 3);
    chk("t6_level", 32'(key_level), 3);
    ticks(2);
    key_n[0] = 1'b1;
    ticks(8);
    chk("t6_indep_level", 32'(key_level), 2);
    ticks(9);
    chk("t6_pre_repeat", 32'(key_pulse), 0);
    tick();
    chk("t6_repeat", 32'(key_pulse), 2);
    chk("t6_k0_count", 32'(p0q.size()), 1);
    key_n = 2'b11;
    ticks(10);
    chk("t6_released", 32'(key_level), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
